pn_eval_engine: RTL and testbench
=================================

// Module: pn_eval_engine
// PURPOSE
//  Parametrised Polish-notation evaluator, successor of the fixed 4-bit PN core.
//  Captures a token stream, evaluates it with an internal register stack and, in
//  burst mode, sorts the results. Streams results out one per cycle.
//  Sits between the token front end and the result checker on the final datapath.
// PARAMETERS
//  IN_W      3   operand/opcode token width (operands unsigned, zero-extended)
//  OUT_W     32  signed result/accumulator width; all arithmetic wraps mod 2^OUT_W
//  MAX_TOK   16  token buffer depth (tokens per expression stream)
//  STK_DEPTH 8   evaluation stack depth (entries of OUT_W bits)
//  MAX_RES   4   result buffer depth (burst groups per stream)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        async reset, active low
//  mode       in   2        sampled on first in_valid cycle: 0 prefix-burst, 1 postfix-burst, 2 prefix, 3 postfix
//  operator   in   1        1: in is opcode, 0: in is operand
//  in         in   IN_W     token value; opcode[1:0]: 00 a+b, 01 a-b, 10 a*b, 11 |a+b|
//  in_valid   in   1        token strobe; contiguous high run = one stream
//  out_valid  out  1        result beat valid
//  out        out  OUT_W    signed result, 0 when out_valid=0
//  err        out  1        stream error flag, valid with out_valid
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low (clk, rst_n).
//  Reset: out_valid=0, out=0, err=0, FSM=IDLE, stack/token/result counters=0.
//  FSM: IDLE -in_valid-> READ; READ -!in_valid-> EVAL; EVAL -last token or error-> SORT
//   (burst) / OUT (single or error); SORT -no swap in full pass-> OUT; OUT -N beats-> IDLE.
//  READ: one token/cycle into buffer, first token stored in IDLE->READ cycle.
//   Tokens beyond MAX_TOK dropped, err latched.
//  in_valid outside IDLE/READ ignored; no token is stored.
//  EVAL: one token per cycle. Postfix scans index 0..len-1; prefix scans len-1..0.
//   Operand: push zero-extended value. Operator: pop two and push result in the same cycle.
//   Postfix: first pop=b, second pop=a. Prefix: first pop=a, second pop=b. Result = a op b.
//  Single modes: end of scan requires depth==1; the result is the popped top.
//  Burst modes: stream is groups of 3 tokens (postfix a b op / prefix op a b).
//   Each group gives one result into result buffer; stack must be empty between groups.
//  Errors (err=1): push at depth STK_DEPTH, pop at depth<2, final depth!=1,
//   len not multiple of 3 in burst, groups>MAX_RES, buffer overflow.
//   On error skip SORT; emit exactly one beat out=0, err=1.
//  |a+b|: two's-complement negate if wrapped sum is negative; most-negative value stays.
//  SORT: bubble sort of N results, descending signed, one compare-swap per cycle; stable.
//  OUT: out_valid high N consecutive cycles (N=1 single), err=0, then IDLE.
//   A new stream may start the cycle after the last beat.
//  Latency bound: first beat <= MAX_TOK + MAX_RES*MAX_RES + 4 cycles after in_valid falls.
//  rst_n low mid-operation: immediate return to reset state; partial stream discarded.
// TESTING
//  mode=3, tokens 3 4 + 2 * -> single beat out=14, err=0
//  mode=2, tokens - * 3 4 5 -> single beat out=7 (3*4=12, 12-5)
//  mode=1, 1 2 - | 3 3 * | 7 0 + | 2 5 op3 -> 4 beats 9,7,7,-1
//  mode=3, tokens 3 + -> underflow: one beat out=0, err=1; next stream 1 1 + -> out=2
//  OUT_W=8, mode=3, tokens 7 7 * 7 * -> out=87 (343 mod 256)
//  assert rst_n low during EVAL -> outputs 0 at once; next stream 2 3 * (mode 3) -> out=6

Source files
------------

// File: rtl/pn_eval_engine.sv
// pn_eval_engine: Polish-notation evaluator with burst-mode result sorting.
//   Captures one token stream (a contiguous in_valid run), evaluates it on an
//   internal register stack, bubble-sorts burst results descending and streams
//   them out one beat per cycle.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous reset, active low
//   mode      0 prefix-burst, 1 postfix-burst, 2 prefix, 3 postfix (first in_valid cycle)
//   operator  1: in carries an opcode, 0: in carries an operand
//   in        token value; opcode[1:0]: 00 a+b, 01 a-b, 10 a*b, 11 |a+b|
//   in_valid  token strobe
//   out_valid result beat valid
//   out       signed result, 0 while out_valid is low
//   err       stream error flag, only asserted with out_valid
module pn_eval_engine #(
  parameter int unsigned IN_W      = 3,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned MAX_TOK   = 16,
  parameter int unsigned STK_DEPTH = 8,
  parameter int unsigned MAX_RES   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             operator,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             err
);

  localparam int unsigned TOK_CW = $clog2(MAX_TOK + 1);
  localparam int unsigned TI_W   = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam int unsigned SP_W   = $clog2(STK_DEPTH + 1);
  localparam int unsigned SI_W   = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int unsigned RES_CW = $clog2(MAX_RES + 1);
  localparam int unsigned RI_W   = (MAX_RES > 1) ? $clog2(MAX_RES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_SORT,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [1:0]              mode_r;
  logic                    tok_op  [MAX_TOK];
  logic [IN_W-1:0]         tok_val [MAX_TOK];
  logic [TOK_CW-1:0]       tok_cnt;
  logic [TOK_CW-1:0]       step;
  logic                    ovf;
  logic signed [OUT_W-1:0] stk [STK_DEPTH];
  logic [SP_W-1:0]         sp;
  logic [1:0]              grp_pos;
  logic signed [OUT_W-1:0] res [MAX_RES];
  logic [RES_CW-1:0]       res_cnt;
  logic [RES_CW-1:0]       sj;
  logic [RES_CW-1:0]       out_idx;
  logic                    swapped;
  logic                    err_r;

  // evaluation datapath
  logic                    burst, postfix, last;
  logic [TOK_CW-1:0]       pos;
  logic                    cur_op;
  logic [IN_W-1:0]         cur_val;
  logic signed [OUT_W-1:0] top, nxt, a, b, sum, alu, push_val, new_top;
  logic [SP_W-1:0]         new_sp;
  logic [SI_W-1:0]         wr_idx;
  logic                    tok_err, grp_end, end_err, pre_err, eval_err;

  // sort / output control
  logic [RES_CW-1:0]       sj1;
  logic                    cmp_swap, pass_end, sort_done, out_last;

  always_comb begin
    burst    = ~mode_r[1];
    postfix  = mode_r[0];
    last     = (step == tok_cnt - TOK_CW'(1));
    // prefix is evaluated by scanning the buffer backwards
    pos      = postfix ? step : (tok_cnt - TOK_CW'(1) - step);
    cur_op   = tok_op[TI_W'(pos)];
    cur_val  = tok_val[TI_W'(pos)];
    top      = stk[SI_W'(sp - SP_W'(1))];
    nxt      = stk[SI_W'(sp - SP_W'(2))];
    // first pop is b for postfix, a for prefix
    a        = postfix ? nxt : top;
    b        = postfix ? top : nxt;
    sum      = a + b;
    case (cur_val[1:0])
      2'b00:   alu = sum;
      2'b01:   alu = a - b;
      2'b10:   alu = a * b;
      default: alu = sum[OUT_W-1] ? -sum : sum;
    endcase
    push_val = OUT_W'(cur_val);
    new_top  = cur_op ? alu : push_val;
    new_sp   = cur_op ? (sp - SP_W'(1)) : (sp + SP_W'(1));
    wr_idx   = cur_op ? SI_W'(sp - SP_W'(2)) : SI_W'(sp);
    tok_err  = cur_op ? (sp < SP_W'(2)) : (sp == SP_W'(STK_DEPTH));
    grp_end  = burst && (grp_pos == 2'd2);
    end_err  = (grp_end || (!burst && last)) && (new_sp != SP_W'(1));
    pre_err  = ovf || (burst && (((tok_cnt % TOK_CW'(3)) != '0) ||
                                 ((tok_cnt / TOK_CW'(3)) > TOK_CW'(MAX_RES))));
    eval_err = pre_err || tok_err || end_err;

    sj1       = sj + RES_CW'(1);
    cmp_swap  = res[RI_W'(sj)] < res[RI_W'(sj1)];
    pass_end  = (sj == res_cnt - RES_CW'(2));
    sort_done = (res_cnt < RES_CW'(2)) || (pass_end && !swapped && !cmp_swap);
    out_last  = err_r || (out_idx == res_cnt - RES_CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out       = '0;
    err       = 1'b0;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_READ;
      S_READ: if (!in_valid) state_nxt = S_EVAL;
      S_EVAL: begin
        if (eval_err)  state_nxt = S_OUT;
        else if (last) state_nxt = burst ? S_SORT : S_OUT;
      end
      S_SORT: if (sort_done) state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        err       = err_r;
        out       = err_r ? '0 : res[RI_W'(out_idx)];
        if (out_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= '0;
      tok_cnt <= '0;
      step    <= '0;
      ovf     <= 1'b0;
      sp      <= '0;
      grp_pos <= '0;
      res_cnt <= '0;
      sj      <= '0;
      out_idx <= '0;
      swapped <= 1'b0;
      err_r   <= 1'b0;
      for (int unsigned i = 0; i < MAX_TOK; i++) begin
        tok_op[i]  <= 1'b0;
        tok_val[i] <= '0;
      end
      for (int unsigned i = 0; i < STK_DEPTH; i++) stk[i] <= '0;
      for (int unsigned i = 0; i < MAX_RES; i++)   res[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          step    <= '0;
          sp      <= '0;
          grp_pos <= '0;
          res_cnt <= '0;
          sj      <= '0;
          out_idx <= '0;
          swapped <= 1'b0;
          if (in_valid) begin
            mode_r     <= mode;
            tok_op[0]  <= operator;
            tok_val[0] <= in;
            tok_cnt    <= TOK_CW'(1);
            ovf        <= 1'b0;
            err_r      <= 1'b0;
          end
        end
        S_READ: begin
          if (in_valid) begin
            if (tok_cnt < TOK_CW'(MAX_TOK)) begin
              tok_op[TI_W'(tok_cnt)]  <= operator;
              tok_val[TI_W'(tok_cnt)] <= in;
              tok_cnt                 <= tok_cnt + TOK_CW'(1);
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          if (eval_err) begin
            err_r <= 1'b1;
          end else begin
            step    <= step + TOK_CW'(1);
            grp_pos <= (grp_pos == 2'd2) ? 2'd0 : (grp_pos + 2'd1);
            // a completed group leaves exactly one entry: move it out and empty the stack
            if (grp_end) begin
              res[RI_W'(res_cnt)] <= new_top;
              res_cnt             <= res_cnt + RES_CW'(1);
              sp                  <= '0;
            end else if (!burst && last) begin
              res[0]  <= new_top;
              res_cnt <= RES_CW'(1);
            end else begin
              stk[wr_idx] <= new_top;
              sp          <= new_sp;
            end
          end
        end
        S_SORT: begin
          if (res_cnt >= RES_CW'(2)) begin
            if (cmp_swap) begin
              res[RI_W'(sj)]  <= res[RI_W'(sj1)];
              res[RI_W'(sj1)] <= res[RI_W'(sj)];
            end
            if (pass_end) begin
              sj      <= '0;
              swapped <= 1'b0;
            end else begin
              sj      <= sj1;
              swapped <= swapped | cmp_swap;
            end
          end
        end
        S_OUT: out_idx <= out_idx + RES_CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_eval_engine.sv
module tb_pn_eval_engine;

  localparam int unsigned MAX_TOK   = 16;
  localparam int unsigned STK_DEPTH = 8;
  localparam int unsigned MAX_RES   = 4;
  localparam int LAT_MAX = MAX_TOK + MAX_RES * MAX_RES + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        operator;
  logic [2:0]  in;
  logic        in_valid;
  logic        ov32, er32, ov8, er8;
  logic [31:0] o32;
  logic [7:0]  o8;

  int checks = 0;
  int errors = 0;

  bit     tq_op[$];
  int     tq_val[$];
  longint mq[$];
  bit     merr;
  longint gv32[$], gv8[$];
  bit     ge32[$], ge8[$];

  pn_eval_engine dut32 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .operator(operator), .in(in),
    .in_valid(in_valid), .out_valid(ov32), .out(o32), .err(er32)
  );

  pn_eval_engine #(.OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .operator(operator), .in(in),
    .in_valid(in_valid), .out_valid(ov8), .out(o8), .err(er8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = (longint'(1) << w) - 1;
    r = v & m;
    if (((r >> (w - 1)) & 1) != 0) r = r - (longint'(1) << w);
    return r;
  endfunction

  task automatic clr();
    tq_op.delete();
    tq_val.delete();
  endtask

  task automatic tk(input bit op, input int v);
    tq_op.push_back(op);
    tq_val.push_back(v);
  endtask

  // Reference: stack machine over the token list, results sorted descending (stable).
  task automatic model(input int w, input int md);
    longint st[$];
    longint rs[$];
    longint x, y, a, b, r, t;
    int n, idx, j;
    bit burst, post;
    mq.delete();
    merr  = 0;
    n     = tq_val.size();
    burst = (md < 2);
    post  = (md % 2 == 1);
    if (n > int'(MAX_TOK)) merr = 1;
    if (burst && ((n % 3 != 0) || (n / 3 > int'(MAX_RES)))) merr = 1;
    for (int k = 0; k < n && !merr; k++) begin
      idx = post ? k : n - 1 - k;
      if (!tq_op[idx]) begin
        if (st.size() == int'(STK_DEPTH)) merr = 1;
        else st.push_back(longint'(tq_val[idx]));
      end else if (st.size() < 2) begin
        merr = 1;
      end else begin
        x = st.pop_back();
        y = st.pop_back();
        a = post ? y : x;
        b = post ? x : y;
        case (tq_val[idx] % 4)
          0: r = a + b;
          1: r = a - b;
          2: r = a * b;
          default: begin
            r = wrapw(a + b, w);
            if (r < 0) r = -r;
          end
        endcase
        st.push_back(wrapw(r, w));
      end
      if (!merr && burst && (k % 3 == 2)) begin
        if (st.size() != 1) merr = 1;
        else rs.push_back(st.pop_back());
      end
    end
    if (!merr && !burst) begin
      if (st.size() != 1) merr = 1;
      else rs.push_back(st[0]);
    end
    if (!merr) begin
      for (int i = 1; i < rs.size(); i++) begin
        t = rs[i];
        j = i - 1;
        while (j >= 0 && rs[j] < t) begin
          rs[j + 1] = rs[j];
          j--;
        end
        rs[j + 1] = t;
      end
      mq = rs;
    end
  endtask

  task automatic drive_stream(input int md, input bit glitch);
    @(posedge clk); #1;
    mode     = 2'(md);
    in_valid = 1'b1;
    for (int k = 0; k < tq_val.size(); k++) begin
      operator = tq_op[k];
      in       = 3'(tq_val[k]);
      @(posedge clk); #1;
      mode = 2'($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    operator = 1'($urandom_range(0, 1));
    in       = 3'($urandom_range(0, 7));
    if (glitch) begin
      // tokens offered while the engine is busy must be ignored
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic compare(input string tag, input int sel, input longint evq[$], input bit eerr);
    longint g[$];
    bit     ge[$];
    longint ev[$];
    bit     ee[$];
    int     n;
    if (sel == 32) begin g = gv32; ge = ge32; end
    else begin g = gv8; ge = ge8; end
    if (eerr) begin ev.push_back(0); ee.push_back(1'b1); end
    else foreach (evq[i]) begin ev.push_back(evq[i]); ee.push_back(1'b0); end
    chk({tag, "_beats"}, g.size(), ev.size());
    n = (g.size() < ev.size()) ? g.size() : ev.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_val"}, g[i], ev[i]);
      chk({tag, "_err"}, ge[i], ee[i]);
    end
  endtask

  task automatic run_stream(input string tag, input int md, input bit glitch);
    longint e32[$], e8[$];
    bit r32, r8, d32, d8;
    int l32, l8, idle_bad;
    model(32, md); e32 = mq; r32 = merr;
    model(8, md);  e8 = mq;  r8 = merr;
    drive_stream(md, glitch);
    gv32.delete(); ge32.delete(); gv8.delete(); ge8.delete();
    d32 = 0; d8 = 0; l32 = -1; l8 = -1; idle_bad = 0;
    for (int c = 0; c < 200 && !(d32 && d8); c++) begin
      @(negedge clk);
      if (ov32) begin
        gv32.push_back(longint'($signed(o32))); ge32.push_back(er32);
        if (l32 < 0) l32 = c;
      end else begin
        if (gv32.size() > 0) d32 = 1;
        if (o32 != '0 || er32) idle_bad++;
      end
      if (ov8) begin
        gv8.push_back(longint'($signed(o8))); ge8.push_back(er8);
        if (l8 < 0) l8 = c;
      end else begin
        if (gv8.size() > 0) d8 = 1;
        if (o8 != '0 || er8) idle_bad++;
      end
    end
    chk({tag, "_done"}, longint'(d32 && d8), 1);
    chk({tag, "_idle_zero"}, idle_bad, 0);
    chk({tag, "_latency"}, longint'(l32 >= 0 && l32 <= LAT_MAX + 1 && l8 >= 0 && l8 <= LAT_MAX + 1), 1);
    compare({tag, "_w32"}, 32, e32, r32);
    compare({tag, "_w8"}, 8, e8, r8);
  endtask

  task automatic gen_random(output int md);
    bit po[$];
    int pv[$];
    int g, nops, depth, pushed, fi;
    clr();
    md = $urandom_range(0, 3);
    if (md < 2) begin
      g = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
      for (int i = 0; i < g; i++) begin
        if (md == 1) begin
          tk(0, $urandom_range(0, 7)); tk(0, $urandom_range(0, 7)); tk(1, $urandom_range(0, 3));
        end else begin
          tk(1, $urandom_range(0, 3)); tk(0, $urandom_range(0, 7)); tk(0, $urandom_range(0, 7));
        end
      end
    end else begin
      nops = $urandom_range(1, 8);
      depth = 0;
      pushed = 0;
      while (pushed < nops || depth > 1) begin
        if (pushed < nops && (depth < 2 || (depth < int'(STK_DEPTH) && $urandom_range(0, 1) == 1))) begin
          po.push_back(0); pv.push_back($urandom_range(0, 7)); depth++; pushed++;
        end else begin
          po.push_back(1); pv.push_back($urandom_range(0, 7)); depth--;
        end
      end
      for (int k = 0; k < po.size(); k++) begin
        if (md == 2) begin tq_op.push_front(po[k]); tq_val.push_front(pv[k]); end
        else begin tq_op.push_back(po[k]); tq_val.push_back(pv[k]); end
      end
    end
    if ($urandom_range(0, 7) == 0) begin
      fi = $urandom_range(0, tq_op.size() - 1);
      tq_op[fi] = !tq_op[fi];
    end
  endtask

  initial begin
    int md;
    bit found;
    rst_n = 1'b1; in_valid = 1'b0; mode = '0; operator = 1'b0; in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ov32, 0);
    chk("rst_out", o32, 0);
    chk("rst_err", er32, 0);
    chk("rst_valid8", ov8, 0);
    rst_n = 1'b1;

    clr(); tk(0,3); tk(0,4); tk(1,0); tk(0,2); tk(1,2);
    run_stream("postfix_14", 3, 0);
    clr(); tk(1,1); tk(1,2); tk(0,3); tk(0,4); tk(0,5);
    run_stream("prefix_7", 2, 0);
    clr(); tk(0,1); tk(0,2); tk(1,1); tk(0,3); tk(0,3); tk(1,2);
    tk(0,7); tk(0,0); tk(1,0); tk(0,2); tk(0,5); tk(1,3);
    run_stream("burst_post", 1, 0);
    clr(); tk(1,1); tk(0,1); tk(0,2); tk(1,2); tk(0,3); tk(0,3);
    tk(1,0); tk(0,7); tk(0,0); tk(1,3); tk(0,2); tk(0,5);
    run_stream("burst_pre", 0, 1);
    clr(); tk(0,3); tk(1,0);
    run_stream("underflow", 3, 0);
    clr(); tk(0,1); tk(0,1); tk(1,0);
    run_stream("after_err", 3, 0);
    clr(); tk(0,7); tk(0,7); tk(1,2); tk(0,7); tk(1,2);
    run_stream("wrap_343", 3, 0);
    clr(); tk(0,4); tk(0,4); tk(1,2); tk(0,4); tk(1,2); tk(0,2); tk(1,2); tk(0,0); tk(1,3);
    run_stream("abs_minneg", 3, 0);
    clr(); for (int i = 0; i < 8; i++) tk(0, i); for (int i = 0; i < 7; i++) tk(1, 0);
    run_stream("depth_full", 3, 0);
    clr(); for (int i = 0; i < 9; i++) tk(0, 1); for (int i = 0; i < 7; i++) tk(1, 0);
    run_stream("stack_ovf", 3, 0);
    clr(); tk(0,1); for (int i = 0; i < 8; i++) begin tk(0, 1); tk(1, 0); end
    run_stream("tok_ovf", 3, 0);
    clr(); tk(0,1); tk(0,2);
    run_stream("depth_two", 3, 0);
    clr(); tk(0,1); tk(0,2); tk(1,0); tk(0,3);
    run_stream("burst_len", 1, 0);
    clr(); for (int i = 0; i < 5; i++) begin tk(0, i); tk(0, 1); tk(1, 0); end
    run_stream("burst_groups", 1, 0);

    // reset while results are streaming out
    clr(); tk(0,1); tk(0,2); tk(1,1); tk(0,3); tk(0,3); tk(1,2);
    drive_stream(1, 0);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (ov32) found = 1;
    end
    chk("rst_out_seen", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", ov32, 0);
    chk("rst_mid_out", o32, 0);
    chk("rst_mid_err", er32, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset while evaluating: the partial stream must be discarded
    clr(); for (int i = 0; i < 8; i++) tk(0, i); for (int i = 0; i < 7; i++) tk(1, 0);
    drive_stream(3, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_eval_valid", ov32, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr(); tk(0,2); tk(0,3); tk(1,2);
    run_stream("after_rst", 3, 0);

    for (int r = 0; r < 40; r++) begin
      gen_random(md);
      run_stream("rand", md, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
